// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter for the shared single-port instruction/data memory.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DATA_BASE  = 8192,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_fault,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DATA_BASE);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must be in 1..15");
    end

    typedef enum logic [1:0] {OwnNone, OwnIf, OwnD} owner_e;

    owner_e            owner_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              fault_q;
    logic              force_if;
    logic              d_allowed;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_q;

    assign force_if = (starve_q == 4'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (reset || !if_req || if_gnt) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_q + 4'd1;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    assign d_allowed = (d_addr >= BASE_ADDR);

    always_comb begin
        if_gnt  = ~reset & if_req & (~d_req | force_if);
        d_gnt   = ~reset & d_req & ~(if_req & force_if);
        m_en    = if_gnt | d_gnt;
        m_we    = d_gnt & d_we & d_allowed;
        m_addr  = d_gnt ? d_addr : if_addr;
        m_wdata = d_gnt ? d_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= OwnNone;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            fault_q    <= 1'b0;
        end else begin
            // Blocked stores still read the array; tag NONE so that data is dropped.
            if (if_gnt) begin
                owner_q <= OwnIf;
            end else if (d_gnt && !d_we) begin
                owner_q <= OwnD;
            end else begin
                owner_q <= OwnNone;
            end
            if (owner_q == OwnIf) begin
                if_rdata_q <= m_rdata;
            end
            if (owner_q == OwnD) begin
                d_rdata_q <= m_rdata;
            end
            fault_q <= d_gnt & d_we & ~d_allowed;
        end
    end

    // Gating with reset discards a read whose return cycle coincides with reset.
    always_comb begin
        if_rvalid = ~reset & (owner_q == OwnIf);
        d_rvalid  = ~reset & (owner_q == OwnD);
        d_fault   = fault_q;
        if (reset) begin
            if_rdata = '0;
            d_rdata  = '0;
        end else begin
            if_rdata = (owner_q == OwnIf) ? m_rdata : if_rdata_q;
            d_rdata  = (owner_q == OwnD) ? m_rdata : d_rdata_q;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a synchronous word-array memory model.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_fault;
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    logic [DATA_W-1:0] mem [16384];
    logic [DATA_W-1:0] prog [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            m_rdata <= mem[m_addr];
        end
    end

    mem_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_fault  (d_fault),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b1; if_addr = '0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 14'd8192; d_wdata = '0;
        step(); step();
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL rst_if_gnt got %b want 0", if_gnt); end
        checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL rst_d_gnt got %b want 0", d_gnt); end
        checks++; if ({m_en, m_we} !== 2'b00) begin errors++; $display("FAIL rst_m_en_we got %b want 00", {m_en, m_we}); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_rdata got %h/%h want 0/0", if_rdata, d_rdata);
        end
        @(negedge clk);
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
        #1;
        checks++; if ({if_rvalid, d_rvalid, d_fault} !== 3'b000) begin
            errors++; $display("FAIL rst_valids got %b want 000", {if_rvalid, d_rvalid, d_fault});
        end
    endtask

    task automatic test_fetch_only();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 14'(i);
            #1;
            checks++; if (if_gnt !== 1'b1 || m_addr !== 14'(i)) begin
                errors++; $display("FAIL fetch_gnt[%0d] got gnt=%b addr=%0d want 1/%0d", i, if_gnt, m_addr, i);
            end
            if (i == 0) begin
                checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid0 got %b want 0", if_rvalid); end
            end else begin
                checks++; if (if_rvalid !== 1'b1 || if_rdata !== prog[i-1]) begin
                    errors++; $display("FAIL fetch_data[%0d] got %b/%h want 1/%h", i - 1, if_rvalid, if_rdata, prog[i-1]);
                end
            end
        end
        @(negedge clk);
        if_req = 1'b0;
        #1;
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== prog[3]) begin
            errors++; $display("FAIL fetch_data[3] got %b/%h want 1/%h", if_rvalid, if_rdata, prog[3]);
        end
        step();
        checks++; if (if_rvalid !== 1'b0 || if_rdata !== prog[3]) begin
            errors++; $display("FAIL fetch_hold got %b/%h want 0/%h", if_rvalid, if_rdata, prog[3]);
        end
    endtask

    task automatic test_load_store();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 14'd8192; d_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (d_gnt !== 1'b1 || m_we !== 1'b1 || m_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL ls_store got gnt=%b we=%b wdata=%h want 1/1/deadbeef", d_gnt, m_we, m_wdata);
        end
        @(negedge clk);
        d_we = 1'b0;
        #1;
        checks++; if (d_gnt !== 1'b1 || m_we !== 1'b0 || d_rvalid !== 1'b0 || d_fault !== 1'b0) begin
            errors++; $display("FAIL ls_load got gnt=%b we=%b rv=%b flt=%b want 1/0/0/0", d_gnt, m_we, d_rvalid, d_fault);
        end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF || d_fault !== 1'b0) begin
            errors++; $display("FAIL ls_rdata got %b/%h/%b want 1/deadbeef/0", d_rvalid, d_rdata, d_fault);
        end
    endtask

    task automatic test_contention();
        @(negedge clk);
        if_req = 1'b1; if_addr = 14'd1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 14'd8200;
        #1;
        checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || m_addr !== 14'd8200) begin
            errors++; $display("FAIL cont_c0 got d=%b if=%b addr=%0d want 1/0/8200", d_gnt, if_gnt, m_addr);
        end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        checks++; if (if_gnt !== 1'b1 || d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE0001 || if_rvalid !== 1'b0) begin
            errors++; $display("FAIL cont_c1 got ifg=%b drv=%b drd=%h ifrv=%b want 1/1/cafe0001/0",
                               if_gnt, d_rvalid, d_rdata, if_rvalid);
        end
        @(negedge clk);
        if_req = 1'b0;
        #1;
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== prog[1] || d_rvalid !== 1'b0 || d_rdata !== 32'hCAFE0001) begin
            errors++; $display("FAIL cont_c2 got ifrv=%b ifrd=%h drv=%b drd=%h want 1/%h/0/cafe0001",
                               if_rvalid, if_rdata, d_rvalid, d_rdata, prog[1]);
        end
    endtask

    task automatic test_blocked_store();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 14'd8191; d_wdata = 32'h12345678;
        #1;
        checks++; if (d_gnt !== 1'b1 || m_en !== 1'b1 || m_we !== 1'b0 || d_fault !== 1'b0) begin
            errors++; $display("FAIL blk_grant got gnt=%b en=%b we=%b flt=%b want 1/1/0/0", d_gnt, m_en, m_we, d_fault);
        end
        @(negedge clk);
        d_addr = 14'd8192; d_wdata = 32'h00000055;
        #1;
        checks++; if (d_fault !== 1'b1 || d_rvalid !== 1'b0) begin
            errors++; $display("FAIL blk_fault got flt=%b rv=%b want 1/0", d_fault, d_rvalid);
        end
        checks++; if (d_gnt !== 1'b1 || m_we !== 1'b1) begin
            errors++; $display("FAIL blk_ok_store got gnt=%b we=%b want 1/1", d_gnt, m_we);
        end
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;
        #1;
        checks++; if (d_fault !== 1'b0 || mem[8191] !== 32'h0BADF00D || mem[8192] !== 32'h00000055) begin
            errors++; $display("FAIL blk_mem got flt=%b m8191=%h m8192=%h want 0/0badf00d/00000055",
                               d_fault, mem[8191], mem[8192]);
        end
    endtask

    task automatic test_starvation();
        logic exp_if;
        @(negedge clk);
        if_req = 1'b1; if_addr = 14'd2;
        d_req = 1'b1; d_we = 1'b0; d_addr = 14'd8200;
        for (int c = 1; c <= 10; c++) begin
            #1;
`ifdef ARB_STARVE_GUARD_EN
            exp_if = (c % 5 == 0);
`else
            exp_if = 1'b0;
`endif
            checks++; if (if_gnt !== exp_if || d_gnt !== !exp_if) begin
                errors++; $display("FAIL starve[%0d] got if=%b d=%b want %b/%b", c, if_gnt, d_gnt, exp_if, !exp_if);
            end
            @(negedge clk);
        end
        if_req = 1'b0; d_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 14'd8192;
        #1;
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt got %b want 1", d_gnt); end
        @(negedge clk);
        d_req = 1'b1; if_req = 1'b1; reset = 1'b1;
        #1;
        checks++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0 || d_gnt !== 1'b0 || if_gnt !== 1'b0 || m_en !== 1'b0) begin
            errors++; $display("FAIL mid_reset got rv=%b rd=%h dg=%b ig=%b en=%b want 0/0/0/0/0",
                               d_rvalid, d_rdata, d_gnt, if_gnt, m_en);
        end
        @(negedge clk);
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
        #1;
        checks++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL mid_after got rv=%b rd=%h want 0/0", d_rvalid, d_rdata);
        end
        @(negedge clk);
        d_req = 1'b1;
        #1;
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL mid_resume_gnt got %b want 1", d_gnt); end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h00000055) begin
            errors++; $display("FAIL mid_resume_data got %b/%h want 1/00000055", d_rvalid, d_rdata);
        end
    endtask

    initial begin
        prog[0] = 32'h00500293; prog[1] = 32'h00000313;
        prog[2] = 32'h00628333; prog[3] = 32'hFFF28293;
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) mem[i] = prog[i];
        mem[8191] = 32'h0BADF00D;
        mem[8200] = 32'hCAFE0001;
        m_rdata = '0;

        test_reset();
        test_fetch_only();
        test_load_store();
        test_contention();
        test_blocked_store();
        test_starvation();
        test_reset_mid_read();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
